fft_spectrum_framer: RTL and testbench

- Sits directly upstream of the LCD spectrum display stage and feeds its `o_fft_data` / `o_fft_data_vaild` inputs.
- Takes the streaming complex FFT output and computes an approximate magnitude per bin, scaled and saturated to an 8-bit display height.
- Emits exactly one contiguous burst of the first OUT_BINS bins per displayed frame.
- Paces frames against the display's `lcd_draw_over` so the LCD RAM is refilled only after a full screen draw.

---
 rtl/fft_spectrum_framer_if.sv | 11 +
 rtl/fft_spectrum_framer.sv | 150 +++++++++++++++
 tb/tb_fft_spectrum_framer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_spectrum_framer_if.sv
// Streaming complex FFT beat bus: one bin per fft_valid cycle, fft_last marks the frame end.
// No back-pressure, so the consumer modport has inputs only.
interface fft_spectrum_framer_if;
  logic [15:0] fft_re;
  logic [15:0] fft_im;
  logic        fft_valid;
  logic        fft_last;

  modport master (output fft_re, fft_im, fft_valid, fft_last);
  modport slave  (input  fft_re, fft_im, fft_valid, fft_last);
endinterface

// File: rtl/fft_spectrum_framer.sv
// Converts streaming FFT bins into one burst of OUT_BINS 8-bit display heights per screen,
// paced by lcd_draw_over so the display RAM is only refilled after a complete draw.
module fft_spectrum_framer #(
  parameter int FFT_LEN   = 1024,
  parameter int OUT_BINS  = 320,
  parameter int SHIFT     = 6,
  parameter int MAX_LEVEL = 240,
  parameter bit DC_ZERO   = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  fft_spectrum_framer_if.slave fft,
  input  logic                 lcd_draw_over,
  output logic [7:0]           o_fft_data,
  output logic                 o_fft_data_vaild,
  output logic                 frame_err
);

  localparam int BIN_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;

  typedef enum logic [2:0] {SYNC, ARMED, STREAM, SKIP, HOLD} state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_cnt;
  logic             draw_prev;
  logic             draw_flag;

  logic             v1, dc1;
  logic [15:0]      a1, b1;
  logic             v2, dc2;
  logic [16:0]      mag2;

  logic             beat_last;
  logic             draw_rise;
  logic             at_out_end;
  logic             at_frame_end;
  logic [15:0]      mx, mn;
  logic [16:0]      scaled;

  assign beat_last    = fft.fft_valid & fft.fft_last;
  assign draw_rise    = lcd_draw_over & ~draw_prev;
  assign at_out_end   = (bin_cnt == BIN_W'(OUT_BINS - 1));
  assign at_frame_end = (bin_cnt == BIN_W'(FFT_LEN - 1));

  // -32768 has no positive 16-bit counterpart, so it saturates to 32767.
  function automatic logic [15:0] abs_sat(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7fff;
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  // Framing FSM; its only datapath output is the S1 "emit" valid and DC tag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= SYNC;
      bin_cnt   <= '0;
      draw_prev <= 1'b0;
      draw_flag <= 1'b0;
      frame_err <= 1'b0;
      v1        <= 1'b0;
      dc1       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
      draw_prev <= lcd_draw_over;
      frame_err <= 1'b0;
      v1        <= 1'b0;
      dc1       <= DC_ZERO && (bin_cnt == '0);
      if (fft.fft_valid) bin_cnt <= fft.fft_last ? '0 : bin_cnt + 1'b1;

      unique case (state)
        SYNC: if (beat_last) state <= ARMED;

        ARMED: if (fft.fft_valid) begin
          if (fft.fft_last) begin
            frame_err <= 1'b1;
          end else begin
            v1    <= 1'b1;
            state <= at_out_end ? SKIP : STREAM;
          end
        end

        STREAM: begin
          if (!fft.fft_valid) begin
            frame_err <= 1'b1;
            state     <= SYNC;
          end else if (at_out_end) begin
            v1 <= 1'b1;
            if (fft.fft_last) begin
              state     <= HOLD;
              draw_flag <= draw_rise;
              frame_err <= ~at_frame_end;
            end else begin
              state <= SKIP;
            end
          end else if (fft.fft_last) begin
            frame_err <= 1'b1;
            state     <= ARMED;
          end else begin
            v1 <= 1'b1;
          end
        end

        SKIP: if (beat_last) begin
          state     <= HOLD;
          draw_flag <= draw_rise;
          frame_err <= ~at_frame_end;
        end

        // Only a rising edge seen after entering HOLD releases the next frame.
        HOLD: begin
          if (draw_flag && beat_last) begin
            state     <= ARMED;
            draw_flag <= 1'b0;
          end else if (draw_rise) begin
            draw_flag <= 1'b1;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

  // NOTE: pure datapath registers carry no reset; their valids gate every use.
  always_ff @(posedge sys_clk) begin
    a1   <= abs_sat(fft.fft_re);
    b1   <= abs_sat(fft.fft_im);
    mag2 <= 17'(mx) + 17'(mn >> 1);
  end

  assign mx     = (a1 > b1) ? a1 : b1;
  assign mn     = (a1 > b1) ? b1 : a1;
  assign scaled = mag2 >> SHIFT;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      v2               <= 1'b0;
      dc2              <= 1'b0;
      o_fft_data       <= 8'd0;
      o_fft_data_vaild <= 1'b0;
    end else begin
      v2               <= v1;
      dc2              <= dc1;
      o_fft_data_vaild <= v2;
      if (!v2 || dc2)                   o_fft_data <= 8'd0;
      else if (scaled > 17'(MAX_LEVEL)) o_fft_data <= 8'(MAX_LEVEL);
      else                              o_fft_data <= scaled[7:0];
    end
  end

endmodule

// File: tb/tb_fft_spectrum_framer.sv
// Directed frames with a scoreboard: the driver queues expected heights and output cycles,
// a negedge monitor pops and compares every output beat and counts frame_err pulses.
module tb_fft_spectrum_framer;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       lcd_draw_over;
  logic [7:0] o_fft_data;
  logic       o_fft_data_vaild;
  logic       frame_err;

  fft_spectrum_framer_if bus ();

  fft_spectrum_framer dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .fft              (bus),
    .lcd_draw_over    (lcd_draw_over),
    .o_fft_data       (o_fft_data),
    .o_fft_data_vaild (o_fft_data_vaild),
    .frame_err        (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   err_cnt  = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference height: saturating abs, max + min/2, /64, clamp to 240, bin 0 forced to 0.
  function automatic int exp_val(input logic signed [15:0] re, input logic signed [15:0] im,
                                 input bit dc);
    int a, b, mx, mn, s;
    a = (re < 0) ? -int'(re) : int'(re);
    b = (im < 0) ? -int'(im) : int'(im);
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    s  = (mx + mn / 2) / 64;
    if (dc) return 0;
    return (s > 240) ? 240 : s;
  endfunction

  function automatic logic [15:0] pat_re(input int pat, input int k);
    if (pat == 1 && k == 1) return 16'h8000;
    if (pat == 1 && k == 2) return 16'h0000;
    return 16'(64 * k);
  endfunction

  function automatic logic [15:0] pat_im(input int pat, input int k);
    if (pat == 1 && k == 1) return 16'h8000;
    if (pat == 1 && k == 2) return 16'hff80;
    return 16'h0000;
  endfunction

  always @(negedge sys_clk) begin
    if (frame_err) err_cnt++;
    if (o_fft_data_vaild) begin
      check("beat_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", int'(o_fft_data), int'(e.data));
        check("out_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Drives bins start..start+n-1 back to back; the first emit_n are expected at the output.
  task automatic frame(input int start, input int n, input bit last_end, input int emit_n,
                       input int pat, input int draw_at);
    for (int i = 0; i < n; i++) begin
      int   k;
      exp_t e;
      k = start + i;
      bus.fft_re    = pat_re(pat, k);
      bus.fft_im    = pat_im(pat, k);
      bus.fft_valid = 1'b1;
      bus.fft_last  = last_end && (i == n - 1);
      lcd_draw_over = (i == draw_at);
      if (i < emit_n) begin
        e.data = 8'(exp_val(bus.fft_re, bus.fft_im, k == 0));
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
      end
      step();
    end
    bus.fft_valid = 1'b0;
    bus.fft_last  = 1'b0;
    lcd_draw_over = 1'b0;
  endtask

  task automatic draw_pulse();
    idle(2);
    lcd_draw_over = 1'b1;
    step();
    lcd_draw_over = 1'b0;
    idle(2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst       = 1'b1;
    lcd_draw_over = 1'b0;
    bus.fft_re    = '0;
    bus.fft_im    = '0;
    bus.fft_valid = 1'b0;
    bus.fft_last  = 1'b0;
    idle(3);
    check("rst_valid", int'(o_fft_data_vaild), 0);
    check("rst_data", int'(o_fft_data), 0);
    check("rst_err", int'(frame_err), 0);
    sys_rst = 1'b0;
    idle(2);

    // SYNC discards the first frame, the second bursts 320 ramp bins.
    frame(0, 1024, 1'b1, 0, 0, -1);
    frame(0, 1024, 1'b1, 320, 0, -1);
    draw_pulse();
    frame(0, 1024, 1'b1, 0, 0, -1);
    // Saturation and abs vectors at bins 1 and 2.
    frame(0, 1024, 1'b1, 320, 1, -1);
    idle(5);
    check("err_after_basic", err_cnt, 0);

    // Draw pacing: two frames with no draw, pulse inside the third, burst on the fourth.
    idle(3);
    frame(0, 1024, 1'b1, 0, 0, -1);
    frame(0, 1024, 1'b1, 0, 0, -1);
    frame(0, 1024, 1'b1, 0, 0, 500);
    frame(0, 1024, 1'b1, 320, 0, -1);
    idle(5);
    check("err_after_pacing", err_cnt, 0);

    // Gap at bin 100 during STREAM.
    draw_pulse();
    frame(0, 1024, 1'b1, 0, 0, -1);
    frame(0, 100, 1'b0, 100, 0, -1);
    idle(1);
    frame(100, 924, 1'b1, 0, 0, -1);
    idle(5);
    check("err_after_gap", err_cnt, 1);
    frame(0, 1024, 1'b1, 320, 0, -1);
    idle(5);

    // Early fft_last at bin 50, then an immediate new burst.
    draw_pulse();
    frame(0, 1024, 1'b1, 0, 0, -1);
    frame(0, 51, 1'b1, 50, 0, -1);
    frame(0, 1024, 1'b1, 320, 0, -1);
    idle(5);
    check("err_after_early_last", err_cnt, 2);

    // Reset in the middle of a burst: outputs up to bin 197 have already left the pipeline.
    draw_pulse();
    frame(0, 1024, 1'b1, 0, 0, -1);
    frame(0, 200, 1'b0, 198, 0, -1);
    sys_rst = 1'b1;
    step();
    check("midrst_valid", int'(o_fft_data_vaild), 0);
    check("midrst_data", int'(o_fft_data), 0);
    step();
    sys_rst = 1'b0;
    idle(3);
    frame(0, 1024, 1'b1, 0, 0, -1);
    frame(0, 1024, 1'b1, 320, 0, -1);
    idle(10);

    check("queue_drained", exp_q.size(), 0);
    check("err_total", err_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
